tx_uart_module: RTL and testbench
=================================

# tx_uart_module

Serial UART transmitter: accepts an 8-bit byte on a one-cycle request and shifts it out LSB-first as start bit, 8 data bits and STOP_BITS stop bits on a single line. Each bit is held for exactly CLKS_PER_BIT clock cycles. It is the transmit counterpart of the series-port receive path and uses the same bit-period counting scheme, so both ends agree on line rate (default 1000 kbps at 100 MHz). There is no parity, no FIFO and no flow control.

## Interface
Parameters:
- CLKS_PER_BIT, 100, clock cycles per serial bit; legal range 2..65535.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RSTn  input  1  reset, asynchronous, active-low.
- TX_En  input  1  send request; sampled only while idle.
- TX_Data  input  8  byte to send; sampled on the accepting edge only.
- TX_Pin_Out  output  1  serial line, registered; idle/mark = 1.
- TX_Busy  output  1  high from the accepting edge until the last stop bit ends.
- TX_Done  output  1  one-cycle pulse after a frame completes.

## Operation
- States: IDLE, START, DATA, STOP.
- IDLE:
  - TX_Pin_Out=1, TX_Busy=0.
  - TX_En=1 at an edge: latch TX_Data into the shift register, set TX_Busy<=1, TX_Pin_Out<=0, go to START.
- Bit strobe: the bit counter drives a strobe, BPS_CLK. BPS_CLK=1 when the count equals CLKS_PER_BIT-1. Every state transition occurs on a strobe edge.
- START, on strobe: TX_Pin_Out<=shift[0], bit index<=0, go to DATA.
- DATA, on strobe:
  - Index<7: shift right, TX_Pin_Out<=next bit, index+1.
  - Index=7: TX_Pin_Out<=1, stop counter<=0, go to STOP.
- STOP, on strobe:
  - Stop counter<STOP_BITS-1: increment it and stay in STOP.
  - Otherwise: go to IDLE, TX_Busy<=0, TX_Done<=1 for exactly one cycle.
- Bit counter:
  - 16-bit, enabled by TX_Busy, held at 0 while TX_Busy=0.
  - Wraps to 0 on the edge where the strobe is high.
- TX_En while busy: ignored, never queued. TX_Data changes while busy have no effect.
- Reset (any time, including mid-frame), immediately:
  - TX_Pin_Out=1, TX_Busy=0, TX_Done=0.
  - State IDLE; counters and shift register cleared.

## Timing
- Accepting edge k: TX_Pin_Out falls at edge k. Bit n (start=0, data 1..8, stop 9..) spans edges k+n·N to k+(n+1)·N, where N=CLKS_PER_BIT.
- Every bit lasts exactly N cycles; no drift over a frame.
- Frame length is (9+STOP_BITS)·N cycles. Default: 1000 cycles.
- TX_Busy=1 from edge k to edge k+(9+STOP_BITS)·N.
- TX_Done=1 for the single cycle that follows.
- Earliest next acceptance is edge k+(9+STOP_BITS)·N+1. The back-to-back line gap is therefore one extra mark cycle.
- The TX_Done cycle is an IDLE cycle, so TX_En=1 in that cycle is accepted at its closing edge.

## Structure
- Shared package uart_pkg holds:
  - state encodings (2 bits),
  - default CLKS_PER_BIT,
  - counter width (16).
- Sub-module tx_bps_module: bit-period counter.
  - Inputs: CLK, RSTn, Count_Sig (= TX_Busy).
  - Output: BPS_CLK (end-of-bit strobe at CLKS_PER_BIT-1).
- Top module: FSM, 8-bit shift register, 3-bit bit index, 1-bit stop counter, output registers.

## Test plan
- Reset: hold RSTn=0 with random inputs, then release. Required: TX_Pin_Out=1, TX_Busy=0, TX_Done=0; no activity without TX_En.
- Single frame, 0x55, N=100:
  - Line reads 0,1,0,1,0,1,0,1,0,1, each exactly 100 cycles from the accepting edge.
  - TX_Done pulses for one cycle at cycle 1000.
- Ignored request: TX_En=1 with 0xFF at cycle 300 of a 0x00 frame.
  - Frame stays 0x00 (start + 8 zeros + stop).
  - No second frame follows.
- Back-to-back: TX_En held high, TX_Data 0xA5 then 0x3C.
  - Second start bit begins exactly 1001 cycles after the first.
  - Both bytes decode correctly LSB-first.
- Mid-frame reset: assert RSTn during data bit 3.
  - TX_Pin_Out=1 and TX_Busy=0 asynchronously, with no TX_Done.
  - After release, a 0x00 request produces a clean 1000-cycle frame.
- STOP_BITS=2, N=4, byte 0x81:
  - Frame 44 cycles; stop high for 8 cycles.
  - TX_Done at cycle 44.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default line rate and widths.
package uart_pkg;

   localparam int unsigned CLKS_PER_BIT_DEF = 100;   // 1000 kbps at 100 MHz
   localparam int unsigned CNT_W            = 16;    // bit-period counter width
   localparam int unsigned DATA_W           = 8;     // payload byte width
   localparam int unsigned IDX_W            = 3;     // data bit index width

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

endpackage

// File: rtl/tx_uart_module_if.sv
// Transmit request/status bundle between a byte source and the UART transmitter.
//   TX_En      : one-cycle send request (source -> tx)
//   TX_Data    : byte to send, sampled on the accepting edge (source -> tx)
//   TX_Pin_Out : serial line, idle high (tx -> line)
//   TX_Busy    : frame in progress (tx -> source)
//   TX_Done    : one-cycle end-of-frame pulse (tx -> source)
interface tx_uart_module_if;
   import uart_pkg::*;

   logic              TX_En;
   logic [DATA_W-1:0] TX_Data;
   logic              TX_Pin_Out;
   logic              TX_Busy;
   logic              TX_Done;

   modport master (
      output TX_En, TX_Data,
      input  TX_Pin_Out, TX_Busy, TX_Done
   );

   modport slave (
      input  TX_En, TX_Data,
      output TX_Pin_Out, TX_Busy, TX_Done
   );

endinterface

// File: rtl/tx_bps_module.sv
// Bit-period counter: counts while Count_Sig is high and raises BPS_CLK in the
// last cycle of every bit period (count == CLKS_PER_BIT-1), then wraps to 0.
//   CLK       : system clock
//   RSTn      : asynchronous active-low reset
//   Count_Sig : count enable (TX_Busy); counter held at 0 while low
//   BPS_CLK   : end-of-bit strobe
module tx_bps_module
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic CLK,
   input  logic RSTn,
   input  logic Count_Sig,
   output logic BPS_CLK
);

   logic [CNT_W-1:0] cnt_q;

   // Strobe is a decode of the count so the FSM sees it in the same cycle.
   assign BPS_CLK = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         cnt_q <= '0;
      end else if (!Count_Sig || BPS_CLK) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/tx_uart_module.sv
// UART transmitter: 8N1 (or 8N2) framing, LSB first, each bit CLKS_PER_BIT cycles.
//   CLK   : system clock
//   RSTn  : asynchronous active-low reset
//   bus   : slave side of tx_uart_module_if (TX_En/TX_Data in; TX_Pin_Out,
//           TX_Busy, TX_Done out, all registered)
module tx_uart_module
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                    CLK,
   input  logic                    RSTn,
   tx_uart_module_if.slave         bus
);

   // Value of the stop counter during the final stop bit.
   localparam logic LAST_STOP = 1'(STOP_BITS - 1);

   tx_state_t         state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [IDX_W-1:0]  idx_q,   idx_d;
   logic              stop_q,  stop_d;
   logic              pin_q,   pin_d;
   logic              busy_q,  busy_d;
   logic              done_q,  done_d;
   logic              bps_clk;

   tx_bps_module #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bps (
      .CLK       (CLK),
      .RSTn      (RSTn),
      .Count_Sig (busy_q),
      .BPS_CLK   (bps_clk)
   );

   // State and output registers.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q <= IDLE;
         shift_q <= '0;
         idx_q   <= '0;
         stop_q  <= 1'b0;
         pin_q   <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         stop_q  <= stop_d;
         pin_q   <= pin_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state and next-output logic; all transitions after IDLE wait for the strobe.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      stop_d  = stop_q;
      pin_d   = pin_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            pin_d  = 1'b1;
            busy_d = 1'b0;
            if (bus.TX_En) begin
               shift_d = bus.TX_Data;
               busy_d  = 1'b1;
               pin_d   = 1'b0;
               state_d = START;
            end
         end
         START: begin
            if (bps_clk) begin
               pin_d   = shift_q[0];
               idx_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (bps_clk) begin
               if (idx_q != IDX_W'(DATA_W - 1)) begin
                  // Bit 1 of the current shift value is the next bit on the line.
                  shift_d = shift_q >> 1;
                  pin_d   = shift_q[1];
                  idx_d   = idx_q + IDX_W'(1);
               end else begin
                  pin_d   = 1'b1;
                  stop_d  = 1'b0;
                  state_d = STOP;
               end
            end
         end
         STOP: begin
            if (bps_clk) begin
               if (stop_q != LAST_STOP) begin
                  stop_d = stop_q + 1'b1;
               end else begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.TX_Pin_Out = pin_q;
   assign bus.TX_Busy    = busy_q;
   assign bus.TX_Done    = done_q;

endmodule

// File: tb/tb_tx_uart_module.sv
`timescale 1ns/1ps
// Two transmitters (N=100/1 stop and N=4/2 stop) checked cycle by cycle
// against a frame-level model of the serial line.
module tb_tx_uart_module;
   import uart_pkg::*;

   typedef struct {
      int         k;   // accepting edge
      logic [7:0] b;   // byte
   } frame_t;

   localparam int NL = 2;
   localparam int N_L [NL] = '{100, 4};
   localparam int S_L [NL] = '{1, 2};

   logic          CLK = 1'b0;
   logic          RSTn;
   logic [NL-1:0] en;
   logic [7:0]    data [NL];
   logic [NL-1:0] pin, busy, done;

   int     cyc = 0;
   int     checks = 0;
   int     errors = 0;
   int     next_free [NL];
   frame_t sb [NL][$];

   always #5 CLK = ~CLK;

   for (genvar g = 0; g < NL; g++) begin : lane
      tx_uart_module_if bus ();
      assign bus.TX_En   = en[g];
      assign bus.TX_Data = data[g];
      assign pin[g]      = bus.TX_Pin_Out;
      assign busy[g]     = bus.TX_Busy;
      assign done[g]     = bus.TX_Done;

      tx_uart_module #(
         .CLKS_PER_BIT (N_L[g]),
         .STOP_BITS    (S_L[g])
      ) dut (
         .CLK  (CLK),
         .RSTn (RSTn),
         .bus  (bus.slave)
      );
   end

   // Reference acceptance model: a request is taken at an edge only when the
   // previous frame and its done cycle are over.
   always @(posedge CLK) begin : model
      frame_t f;
      cyc = cyc + 1;
      for (int l = 0; l < NL; l++) begin
         if (!RSTn) begin
            next_free[l] = 0;
         end else if (en[l] && cyc >= next_free[l]) begin
            f.k = cyc;
            f.b = data[l];
            sb[l].push_back(f);
            next_free[l] = cyc + (9 + S_L[l]) * N_L[l] + 1;
         end
      end
   end

   task automatic check(string nm, int l, logic act, logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s lane%0d cyc %0d: got %b expected %b", nm, l, cyc, act, exp);
      end
   endtask

   // Monitor: derive expected line/busy/done for the state after edge cyc.
   always @(negedge CLK) begin : monitor
      logic   ep, eb, ed;
      int     flen, n;
      frame_t fr;
      for (int l = 0; l < NL; l++) begin
         flen = (9 + S_L[l]) * N_L[l];
         ep = 1'b1; eb = 1'b0; ed = 1'b0;
         if (!RSTn) begin
            sb[l].delete();
         end else begin
            while (sb[l].size() > 0 && cyc > sb[l][0].k + flen)
               void'(sb[l].pop_front());
            if (sb[l].size() > 0 && cyc >= sb[l][0].k) begin
               fr = sb[l][0];
               if (cyc == fr.k + flen) begin
                  ed = 1'b1;
               end else begin
                  eb = 1'b1;
                  n  = (cyc - fr.k) / N_L[l];
                  if (n == 0)      ep = 1'b0;
                  else if (n <= 8) ep = fr.b[n-1];
               end
            end
         end
         check("pin",  l, pin[l],  ep);
         check("busy", l, busy[l], eb);
         check("done", l, done[l], ed);
      end
   end

   task automatic tick(int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic send(int l, logic [7:0] b);
      en[l]   = 1'b1;
      data[l] = b;
      tick(1);
      en[l]   = 1'b0;
      data[l] = 8'($urandom);
   endtask

   initial begin
      RSTn    = 1'b0;
      en      = '0;
      data[0] = 8'h00;
      data[1] = 8'h00;
      // Reset with random inputs, then quiet idle.
      for (int i = 0; i < 6; i++) begin
         en      = 2'($urandom);
         data[0] = 8'($urandom);
         data[1] = 8'($urandom);
         tick(1);
      end
      en   = '0;
      RSTn = 1'b1;
      tick(20);

      // Single frames: 0x55 at N=100, 0x81 at N=4 with two stop bits.
      send(0, 8'h55);
      send(1, 8'h81);
      tick(1020);

      // Request while busy is dropped.
      send(0, 8'h00);
      tick(299);
      en[0]   = 1'b1;
      data[0] = 8'hFF;
      tick(1);
      en[0]   = 1'b0;
      tick(750);

      // Back-to-back with TX_En held high.
      en[0]   = 1'b1;
      data[0] = 8'hA5;
      tick(1);
      data[0] = 8'h3C;
      tick(1010);
      en[0]   = 1'b0;
      tick(1000);

      // Asynchronous reset during data bit 3, then a clean frame.
      send(0, 8'($urandom));
      tick(430);
      RSTn = 1'b0;
      tick(3);
      RSTn = 1'b1;
      tick(5);
      send(0, 8'h00);
      tick(1010);

      // Random request stream on the short-frame lane.
      for (int i = 0; i < 600; i++) begin
         en[1]   = ($urandom_range(0, 7) == 0);
         data[1] = 8'($urandom);
         tick(1);
      end
      en[1] = 1'b0;
      tick(60);

      // Random bytes on the long-frame lane with gaps around the done cycle.
      for (int i = 0; i < 3; i++) begin
         send(0, 8'($urandom));
         tick($urandom_range(998, 1003));
      end
      tick(1100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
